vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Produces HS/VS, active/blanking, pixel coordinates and per-line/per-frame event pulses for any VESA-style mode set by parameters.
- Adds a frame counter, a programmable line-compare pulse and a synchronous frame restart.
- Sits between the pixel-clock strobe divider and the sprite/framebuffer renderers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, 0 = HS active-low, 1 = active-high
- V_SYNC_POL, 0, 0 = VS active-low, 1 = active-high
- FRAME_W, 8, frame counter width
- SYNC_DELAY, 2, strobe delay applied to sync/active outputs (optional feature only)
- Derived localparams:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - XW = clog2(H_ACTIVE), YW = clog2(V_ACTIVE)
  - HCW = clog2(H_TOTAL), VCW = clog2(V_TOTAL)

Ports:
- i_clk  in  1  base clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_stb  in  1  pixel strobe; one pixel per high cycle
- i_restart  in  1  synchronous frame restart
- i_irq_line  in  VCW  line number for o_irq compare
- o_hs  out  1  horizontal sync (polarity per H_SYNC_POL)
- o_vs  out  1  vertical sync (polarity per V_SYNC_POL)
- o_active  out  1  high while drawing a visible pixel
- o_blanking  out  1  inverse of o_active
- o_x  out  XW  visible x coordinate
- o_y  out  YW  visible y coordinate
- o_line_end  out  1  one-clock pulse on the last pixel of every line
- o_animate  out  1  one-clock pulse on the last pixel of the last visible line
- o_frame_end  out  1  one-clock pulse on the last pixel of the frame
- o_irq  out  1  one-clock pulse at the start of line i_irq_line
- o_frame_cnt  out  FRAME_W  completed-frame count

Behaviour:
- Registers:
  - h_cnt (HCW bits), v_cnt (VCW bits), running flag, frame_cnt.
  - All change only on i_clk rising edge, except the async reset.
- Reset (i_rst_n=0, asynchronous):
  - h_cnt=0, v_cnt=0, running=0, frame_cnt=0.
- Idle (running=0) outputs:
  - o_active=0, o_blanking=1, o_hs/o_vs at inactive level, o_x=0, o_y=0.
  - All pulses 0.
- Leaving idle:
  - First i_pix_stb sets running=1 without advancing the counters.
  - Position (0,0) is presented from that edge until the next strobe.
- Running, on i_pix_stb:
  - h_cnt increments, or wraps H_TOTAL-1 -> 0.
  - On the h wrap, v_cnt increments, or wraps V_TOTAL-1 -> 0.
  - Counters hold when i_pix_stb=0.
- Line layout (h, and v identically):
  - Active: 0..H_ACTIVE-1
  - Front porch: H_ACTIVE..+H_FP-1
  - Sync: next H_SYNC counts
  - Back porch: remaining counts up to H_TOTAL-1
- Decoded outputs (combinational from registers, zero latency relative to the counters):
  - o_active = running & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
  - HS asserted while h_cnt is in the sync region; VS asserted while v_cnt is in the sync region.
  - o_x = h_cnt when h_cnt<H_ACTIVE, else 0.
  - o_y = v_cnt when v_cnt<V_ACTIVE, else V_ACTIVE-1.
- Pulses (each qualified by running & i_pix_stb, so high for exactly one i_clk cycle):
  - o_line_end: h_cnt==H_TOTAL-1.
  - o_animate: additionally v_cnt==V_ACTIVE-1.
  - o_frame_end: additionally v_cnt==V_TOTAL-1.
  - o_irq: h_cnt==0 & v_cnt==i_irq_line. An i_irq_line value >= V_TOTAL never fires.
- o_frame_cnt:
  - Increments on each o_frame_end cycle; wraps 2^FRAME_W-1 -> 0.
- i_restart=1:
  - Next edge sets h_cnt=0, v_cnt=0, running=0; frame_cnt is retained.
  - No pulses fire in that cycle.
  - Has priority over a simultaneous i_pix_stb.
- i_irq_line is sampled every cycle; changing it mid-frame takes effect immediately.

Optional Feature:
- Macro: VGA_TIMING_SYNC_DELAY_EN.
- Defined:
  - o_hs, o_vs, o_active and o_blanking pass through a SYNC_DELAY-stage shift register clocked by i_clk and enabled by i_pix_stb, to align with a pipelined pixel path.
  - Async reset fills the stages with the idle levels (syncs inactive, active=0, blanking=1).
  - o_x, o_y and all pulses stay undelayed.
- Undefined:
  - No delay stages; SYNC_DELAY is ignored.

Test Plan:
- Default parameters, i_pix_stb every 4th clock, release reset -> idle outputs until first strobe; then o_x=0, o_y=0, o_active=1; h advances 1 per strobe.
- Run one line -> o_active falls at h=640; o_hs low for h=656..751 (96 strobes); o_line_end single-cycle at h=799; then o_y=1, o_x=0.
- Run two frames -> o_vs low for v=490..491; o_animate once at v=479,h=799; o_frame_end once at v=524,h=799; o_frame_cnt 0->1->2; preload FRAME_W=2 and run 4 frames -> wraps to 0.
- i_irq_line=100 -> o_irq exactly once per frame at v=100,h=0; i_irq_line=600 -> never.
- i_restart at h=300,v=200 with simultaneous strobe -> idle outputs next cycle, o_frame_cnt unchanged, no o_frame_end; next strobe shows (0,0).
- Async i_rst_n low mid-frame without a clock -> idle outputs and o_frame_cnt=0 immediately; with VGA_TIMING_SYNC_DELAY_EN and SYNC_DELAY=2, o_hs falls at counter h=658.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
//------------------------------------------------------------------------------
// vga_timing_gen_if : strobe/control inputs and decoded video timing outputs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vga_timing_gen_if #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int VCW     = 10,
    parameter int FRAME_W = 8
);
    logic               i_pix_stb;
    logic               i_restart;
    logic [VCW-1:0]     i_irq_line;
    logic               o_hs;
    logic               o_vs;
    logic               o_active;
    logic               o_blanking;
    logic [XW-1:0]      o_x;
    logic [YW-1:0]      o_y;
    logic               o_line_end;
    logic               o_animate;
    logic               o_frame_end;
    logic               o_irq;
    logic [FRAME_W-1:0] o_frame_cnt;

    modport master (
        output i_pix_stb, i_restart, i_irq_line,
        input  o_hs, o_vs, o_active, o_blanking, o_x, o_y,
               o_line_end, o_animate, o_frame_end, o_irq, o_frame_cnt
    );

    modport slave (
        input  i_pix_stb, i_restart, i_irq_line,
        output o_hs, o_vs, o_active, o_blanking, o_x, o_y,
               o_line_end, o_animate, o_frame_end, o_irq, o_frame_cnt
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// vga_timing_gen : parametrised VESA-style sync/position/event generator.
// Optional macro VGA_TIMING_SYNC_DELAY_EN delays HS/VS/active/blanking.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int FRAME_W    = 8,
    parameter int SYNC_DELAY = 2
) (
    input wire logic        i_clk,
    input wire logic        i_rst_n,
    vga_timing_gen_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

`ifdef VGA_TIMING_SYNC_DELAY_EN
    localparam int DLY = SYNC_DELAY;
`else
    localparam int DLY = 0 * SYNC_DELAY;
`endif

    localparam logic [HCW-1:0] C_H_ACT  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] C_HS_BEG = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] C_HS_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCW-1:0] C_H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] C_V_ACT  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] C_VS_BEG = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] C_VS_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCW-1:0] C_V_LAST = VCW'(V_TOTAL - 1);
    localparam logic [YW-1:0]  C_Y_MAX  = YW'(V_ACTIVE - 1);
    localparam logic           C_HS_ON  = (H_SYNC_POL != 0);
    localparam logic           C_VS_ON  = (V_SYNC_POL != 0);
    // Packed as {hs, vs, active, blanking}
    localparam logic [3:0]     C_IDLE   = {~C_HS_ON, ~C_VS_ON, 1'b0, 1'b1};

    logic [HCW-1:0]     h_q, h_d;
    logic [VCW-1:0]     v_q, v_d;
    logic               run_q, run_d;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;

    logic w_go, w_line_end, w_frame_end, w_active, w_hs_on, w_vs_on;
    logic [3:0] w_dec, w_sync_out;

    // Restart wins over a coincident strobe and suppresses every pulse
    assign w_go        = run_q & bus.i_pix_stb & ~bus.i_restart;
    assign w_line_end  = w_go & (h_q == C_H_LAST);
    assign w_frame_end = w_line_end & (v_q == C_V_LAST);

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        run_d  = run_q;
        fcnt_d = w_frame_end ? fcnt_q + 1'b1 : fcnt_q;
        if (bus.i_restart) begin
            h_d   = '0;
            v_d   = '0;
            run_d = 1'b0;
        end else if (bus.i_pix_stb) begin
            if (!run_q) begin
                run_d = 1'b1;
            end else if (h_q == C_H_LAST) begin
                h_d = '0;
                v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            run_q  <= 1'b0;
            fcnt_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            run_q  <= run_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign w_active = run_q & (h_q < C_H_ACT) & (v_q < C_V_ACT);
    assign w_hs_on  = run_q & (h_q >= C_HS_BEG) & (h_q < C_HS_END);
    assign w_vs_on  = run_q & (v_q >= C_VS_BEG) & (v_q < C_VS_END);
    assign w_dec    = {w_hs_on ? C_HS_ON : ~C_HS_ON,
                       w_vs_on ? C_VS_ON : ~C_VS_ON,
                       w_active, ~w_active};

    generate
        if (DLY > 0) begin : g_sync_dly
            logic [3:0] dly_q [DLY];
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DLY; i++) dly_q[i] <= C_IDLE;
                end else if (bus.i_pix_stb) begin
                    dly_q[0] <= w_dec;
                    for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign w_sync_out = dly_q[DLY-1];
        end else begin : g_sync_direct
            assign w_sync_out = w_dec;
        end
    endgenerate

    assign bus.o_hs        = w_sync_out[3];
    assign bus.o_vs        = w_sync_out[2];
    assign bus.o_active    = w_sync_out[1];
    assign bus.o_blanking  = w_sync_out[0];
    assign bus.o_x         = (h_q < C_H_ACT) ? h_q[XW-1:0] : '0;
    assign bus.o_y         = (v_q < C_V_ACT) ? v_q[YW-1:0] : C_Y_MAX;
    assign bus.o_line_end  = w_line_end;
    assign bus.o_animate   = w_line_end & (v_q == C_V_ACT - 1'b1);
    assign bus.o_frame_end = w_frame_end;
    assign bus.o_irq       = w_go & (h_q == '0) & (v_q == bus.i_irq_line);
    assign bus.o_frame_cnt = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//------------------------------------------------------------------------------
// tb_vga_timing_gen : scoreboard bench on a reduced 15x10 timing mode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FW = 2;
    localparam int SYNC_DELAY = 2;
`ifdef VGA_TIMING_SYNC_DELAY_EN
    localparam int SD = SYNC_DELAY;
`else
    localparam int SD = 0;
`endif

    typedef struct packed {
        logic [3:0]    sync;
        logic [2:0]    x;
        logic [2:0]    y;
        logic [3:0]    pulses;
        logic [FW-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(3), .YW(3), .VCW(4), .FRAME_W(FW)) bus ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .FRAME_W(FW), .SYNC_DELAY(SYNC_DELAY)
    ) u_dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int n_chk = 0, n_pass = 0;
    int cnt_an = 0, cnt_fe = 0, cnt_irq = 0;
    exp_t q[$];

    int mh, mv, mfc;
    bit mrun;
    logic [3:0] pipe [0:7];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [3:0] dec();
        bit act, hs_on, vs_on;
        act   = mrun && mh < HA && mv < VA;
        hs_on = mrun && mh >= HA + HF && mh < HA + HF + HS;
        vs_on = mrun && mv >= VA + VF && mv < VA + VF + VS;
        return {~hs_on, ~vs_on, act, ~act};
    endfunction

    function automatic exp_t predict(bit stb, bit rs);
        exp_t e;
        bit go, le;
        int idx;
        idx = (SD > 0) ? SD - 1 : 0;
        go  = stb && !rs && mrun;
        le  = go && mh == HT - 1;
        e.sync   = (SD > 0) ? pipe[idx] : dec();
        e.x      = (mh < HA) ? 3'(mh) : 3'd0;
        e.y      = (mv < VA) ? 3'(mv) : 3'(VA - 1);
        e.pulses = {le, le && mv == VA - 1, le && mv == VT - 1,
                    go && mh == 0 && mv == int'(bus.i_irq_line)};
        e.fc     = FW'(mfc);
        return e;
    endfunction

    function automatic void model_reset();
        mh = 0; mv = 0; mrun = 0; mfc = 0;
        for (int i = 0; i < 8; i++) pipe[i] = 4'b1101;
    endfunction

    function automatic void model_edge(bit stb, bit rs);
        logic [3:0] d;
        d = dec();
        if (stb && !rs && mrun && mh == HT - 1 && mv == VT - 1) mfc = (mfc + 1) % (1 << FW);
        if (stb) begin
            for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = d;
        end
        if (rs) begin
            mh = 0; mv = 0; mrun = 0;
        end else if (stb) begin
            if (!mrun) mrun = 1;
            else if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else mh = mh + 1;
        end
    endfunction

    // Entered at posedge+1: drive, predict, sample at posedge+4, then clock the model
    task automatic cycle(input bit stb, input bit rs);
        exp_t e;
        bus.i_pix_stb = stb;
        bus.i_restart = rs;
        q.push_back(predict(stb, rs));
        #3;
        e = q.pop_front();
        chk("sync", {28'd0, bus.o_hs, bus.o_vs, bus.o_active, bus.o_blanking}, {28'd0, e.sync});
        chk("xy", {26'd0, bus.o_x, bus.o_y}, {26'd0, e.x, e.y});
        chk("pulses", {28'd0, bus.o_line_end, bus.o_animate, bus.o_frame_end, bus.o_irq},
            {28'd0, e.pulses});
        chk("frame_cnt", {30'd0, bus.o_frame_cnt}, {30'd0, e.fc});
        if (bus.o_animate) cnt_an++;
        if (bus.o_frame_end) cnt_fe++;
        if (bus.o_irq) cnt_irq++;
        @(posedge clk);
        if (rst_n) model_edge(stb, rs);
        #1;
    endtask

    task automatic run_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        bus.i_pix_stb = 1'b0;
        bus.i_restart = 1'b0;
        bus.i_irq_line = 4'd3;
        model_reset();
        @(posedge clk);
        #1;
        repeat (3) cycle(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (5) cycle(1'b0, 1'b0);
        chk("idle_active", 32'(bus.o_active), 32'd0);
        chk("idle_hs", 32'(bus.o_hs), 32'd1);

        run_strobes(1);
        chk("start_xy", {26'd0, bus.o_x, bus.o_y}, 32'd0);
        chk("start_active", 32'(bus.o_active), (SD > 0) ? 32'd0 : 32'd1);
        run_strobes(1);
        chk("x_step", 32'(bus.o_x), 32'd1);

        // Five full frames: the 2-bit frame counter passes 3 -> 0
        run_strobes(5 * HT * VT - 1);
        chk("frames_fe", cnt_fe, 5);
        chk("frames_anim", cnt_an, 5);
        chk("frames_irq", cnt_irq, 5);
        chk("frames_cnt", 32'(bus.o_frame_cnt), 32'd1);
        chk("frame_wrap_xy", {26'd0, bus.o_x, bus.o_y}, 32'd0);

        bus.i_irq_line = 4'd12;
        cnt_irq = 0;
        cnt_fe = 0;
        run_strobes(HT * VT);
        chk("irq_out_of_range", cnt_irq, 0);
        chk("one_frame_fe", cnt_fe, 1);
        bus.i_irq_line = 4'd3;

        found = 0;
        for (int i = 0; i < 2 * HT * VT && !found; i++) begin
            if (mh == 5 && mv == 4) found = 1;
            else run_strobes(1);
        end
        chk("restart_reach", 32'(found), 32'd1);
        repeat (3) cycle(1'b0, 1'b0);
        cnt_fe = 0;
        cycle(1'b1, 1'b1);
        chk("restart_active", 32'(bus.o_active), 32'd0);
        chk("restart_cnt", 32'(bus.o_frame_cnt), 32'd2);
        chk("restart_xy", {26'd0, bus.o_x, bus.o_y}, 32'd0);
        run_strobes(1);
        chk("restart_fe", cnt_fe, 0);
        chk("restart_resume", 32'(bus.o_active), (SD > 0) ? 32'd0 : 32'd1);
        run_strobes(40);

        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_active", 32'(bus.o_active), 32'd0);
        chk("areset_blank", 32'(bus.o_blanking), 32'd1);
        chk("areset_syncs", {30'd0, bus.o_hs, bus.o_vs}, 32'd3);
        chk("areset_xy", {26'd0, bus.o_x, bus.o_y}, 32'd0);
        chk("areset_cnt", 32'(bus.o_frame_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 1'b0);
        run_strobes(2 * HT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
